cic_integ_decim: RTL and testbench

CIC_INTEG_DECIM -- requirements
Module: cic_integ_decim

---
 rtl/cic_integ_decim.sv | 108 ++++++++++
 tb/tb_cic_integ_decim.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_integ_decim.sv
// -----------------------------------------------------------------------------
// cic_integ_decim
//
// Single-stage (N=1) CIC integrator with built-in decimation by R = 2**LOG2R.
// Every accepted input sample is sign-extended to Wout bits and added into a
// wrapping accumulator. Every R-th accepted sample the new accumulator value,
// including that sample, is registered onto data_out, and val_out pulses for
// one cycle. The outputs feed a downstream comb stage.
//
// Parameters
//   Win    input sample width (signed two's complement), default 16
//   LOG2R  log2 of the decimation factor, legal range 1..6, default 2
//   Wout   Win + LOG2R, output/accumulator width (derived, not overridable)
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst       in   synchronous active-high reset; overrides a same-cycle sample
//   val_in    in   data_in is valid; each high edge is one accepted sample
//   data_in   in   signed input sample, Win bits
//   val_out   out  one-cycle pulse marking a decimated sample
//   data_out  out  signed decimated integrator output, Wout bits
//
// Build option
//   CIC_DEC_ZERO_EN  when defined, data_out reads 0 in every cycle val_out is
//                    low; otherwise data_out holds the last emitted value.
// -----------------------------------------------------------------------------
module cic_integ_decim #(
  parameter  int Win   = 16,
  parameter  int LOG2R = 2,
  localparam int Wout  = Win + LOG2R
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   val_in,
  input  logic signed [Win-1:0]  data_in,
  output logic                   val_out,
  output logic signed [Wout-1:0] data_out
);

  // Last phase of a frame. R-1 is all ones in a LOG2R-bit counter, so the
  // counter wraps from R-1 to 0 by plain binary overflow.
  localparam logic [LOG2R-1:0] CNT_LAST = '1;

  typedef enum logic {
    FILL = 1'b0,  // fewer than R-1 samples of the current frame accepted
    EMIT = 1'b1   // next accepted sample completes the frame
  } state_t;

  function automatic logic signed [Wout-1:0] sext(input logic signed [Win-1:0] x);
    return {{LOG2R{x[Win-1]}}, x};
  endfunction

  state_t                  state_q, state_d;
  logic [LOG2R-1:0]        cnt_q, cnt_d;
  logic signed [Wout-1:0]  acc_q, acc_d;
  logic signed [Wout-1:0]  data_out_q, data_out_d;
  logic                    val_out_q, val_out_d;
  logic                    emit;

  // Next-state: integrate, advance phase, and decide whether this accepted
  // sample closes the frame. Accumulator wraps modulo 2**Wout on purpose:
  // the comb stage's subtraction cancels the wrap.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    emit       = 1'b0;
    val_out_d  = 1'b0;
`ifdef CIC_DEC_ZERO_EN
    data_out_d = '0;
`else
    data_out_d = data_out_q;
`endif

    if (val_in) begin
      acc_d   = acc_q + sext(data_in);
      cnt_d   = cnt_q + 1'b1;
      emit    = (state_q == EMIT);
      state_d = (cnt_d == CNT_LAST) ? EMIT : FILL;
    end

    if (emit) begin
      val_out_d  = 1'b1;
      data_out_d = acc_d;
    end
  end

  // State register; reset clears the partial frame and wins over val_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      val_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      val_out_q  <= val_out_d;
    end
  end

  assign val_out  = val_out_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_cic_integ_decim.sv
module tb_cic_integ_decim;

  localparam int Win   = 16;
  localparam int LOG2R = 2;
  localparam int R     = 1 << LOG2R;
  localparam int Wout  = Win + LOG2R;

`ifdef CIC_DEC_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   val_in;
  logic signed [Win-1:0]  data_in;
  logic                   val_out;
  logic signed [Wout-1:0] data_out;

  always #5 clk = ~clk;

  cic_integ_decim #(.Win(Win), .LOG2R(LOG2R)) dut (
    .clk      (clk),
    .rst      (rst),
    .val_in   (val_in),
    .data_in  (data_in),
    .val_out  (val_out),
    .data_out (data_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic drive_step(input logic r, input logic v, input logic signed [Win-1:0] d);
    rst     = r;
    val_in  = v;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic longint wrapw(input longint x);
    logic signed [Wout-1:0] t;
    t = x[Wout-1:0];
    return longint'(t);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: running arithmetic sum of every accepted sample since the
  // last reset, reduced mod 2**Wout whenever the accepted-sample count reaches
  // a multiple of R.
  // ---------------------------------------------------------------------------
  longint m_total;
  int     m_nacc;
  logic   m_v;
  longint m_d;

  task automatic model_step(input logic r, input logic v, input logic signed [Win-1:0] d);
    if (r) begin
      m_total = 0;
      m_nacc  = 0;
      m_v     = 1'b0;
      m_d     = 0;
    end else if (v) begin
      m_total += longint'(d);
      m_nacc++;
      if (m_nacc % R == 0) begin
        m_v = 1'b1;
        m_d = wrapw(m_total);
      end else begin
        m_v = 1'b0;
      end
    end else begin
      m_v = 1'b0;
    end
  endtask

  function automatic longint exp_data(input logic v, input longint held);
    return (ZERO_EN && !v) ? 0 : held;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic                   r;
    logic                   v;
    logic signed [Win-1:0]  d;
    logic                   ev;
    longint                 ed;   // value held/emitted (zeroed when ZERO_EN && !ev)
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic signed [Win-1:0] d,
                     input logic ev, input longint ed);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.ev = ev; e.ed = ed;
    tbl.push_back(e);
  endtask

  initial begin
    longint prev;
    int     pulses;
    int     gap;
    logic   r, v;
    logic signed [Win-1:0] d;

    rst = 1'b1; val_in = 1'b0; data_in = '0;

    // Continuous ones: pulses with 4 and 8, hold in between.
    add(1, 0, 16'sd0, 0, 0);
    add(0, 1, 16'sd1, 0, 0);
    add(0, 1, 16'sd1, 0, 0);
    add(0, 1, 16'sd1, 0, 0);
    add(0, 1, 16'sd1, 1, 4);
    add(0, 1, 16'sd1, 0, 4);
    add(0, 1, 16'sd1, 0, 4);
    add(0, 1, 16'sd1, 0, 4);
    add(0, 1, 16'sd1, 1, 8);
    add(0, 0, 16'sd0, 0, 8);
    // Full-scale positive: 131068 then 262136 wrapped to -8.
    add(1, 0, 16'sd0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 16'sh7FFF, (i % 4 == 0), (i < 4) ? 0 : ((i < 8) ? 131068 : -8));
    // -1 with val_in toggling: one pulse after the 4th accepted sample.
    add(1, 0, 16'sd0, 0, 0);
    add(0, 1, -16'sd1, 0, 0);
    add(0, 0, 16'sd0, 0, 0);
    add(0, 1, -16'sd1, 0, 0);
    add(0, 0, 16'sd0, 0, 0);
    add(0, 1, -16'sd1, 0, 0);
    add(0, 0, 16'sd0, 0, 0);
    add(0, 1, -16'sd1, 1, -4);
    add(0, 0, 16'sd0, 0, -4);
    add(0, 0, 16'sd0, 0, -4);
    // Mid-frame reset with a simultaneous valid sample, then four 3s.
    add(1, 0, 16'sd0, 0, 0);
    add(0, 1, 16'sd5, 0, 0);
    add(0, 1, 16'sd5, 0, 0);
    add(1, 1, 16'sd5, 0, 0);
    add(0, 1, 16'sd3, 0, 0);
    add(0, 1, 16'sd3, 0, 0);
    add(0, 1, 16'sd3, 0, 0);
    add(0, 1, 16'sd3, 1, 12);
    add(0, 0, 16'sd0, 0, 12);

    for (int i = 0; i < tbl.size(); i++) begin
      drive_step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_val_out", i), longint'(val_out), longint'(tbl[i].ev));
      chk($sformatf("vec%0d_data_out", i), longint'(data_out), exp_data(tbl[i].ev, tbl[i].ed));
    end

    // Cascade with a behavioural comb: output must equal R*d every frame,
    // including across accumulator wrap for full-scale input.
    for (int pass = 0; pass < 2; pass++) begin
      d = (pass == 0) ? 16'sd1 : 16'sh7FFF;
      drive_step(1'b1, 1'b0, '0);
      prev   = 0;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
        drive_step(1'b0, 1'b1, d);
        if (val_out) begin
          pulses++;
          chk($sformatf("comb%0d_out", pass), wrapw(longint'(data_out) - prev),
              wrapw(longint'(R) * longint'(d)));
          prev = longint'(data_out);
        end
      end
      chk($sformatf("comb%0d_pulses", pass), longint'(pulses), 16 / R);
    end

    // Randomized traffic with idle bursts and occasional resets.
    drive_step(1'b1, 1'b0, '0);
    model_step(1'b1, 1'b0, '0);
    gap = 0;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 99) < 2);
      if (gap > 0) begin
        v = 1'b0;
        gap--;
      end else begin
        v = ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 99) < 3) gap = $urandom_range(5, 30);
      end
      d = Win'($urandom);
      drive_step(r, v, d);
      model_step(r, v, d);
      chk($sformatf("rnd%0d_val_out", i), longint'(val_out), longint'(m_v));
      chk($sformatf("rnd%0d_data_out", i), longint'(data_out), exp_data(m_v, m_d));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
